// File: rtl/animation_pkg.sv
`default_nettype none
// ============================================================================
// animation_pkg : shared types and defaults for the animation scheduler (rev 1.0)
// ============================================================================
package animation_pkg;

   localparam int SCALAR_W                 = 16;
   localparam int COLOR_W                  = 4;
   localparam int N_SCALARS                = 3;
   localparam int DEFAULT_N_VIRTUAL_POINTS = 48;
   localparam int DEFAULT_N_FRAMES         = 4;

   typedef logic [N_SCALARS-1:0][SCALAR_W-1:0] scalars_t;
   typedef logic [COLOR_W-1:0]                 color_t;

   typedef enum logic [2:0] {
      ST_IDLE       = 3'd0,
      ST_WAIT_VSYNC = 3'd1,
      ST_ISSUE      = 3'd2,
      ST_WAIT_DATA  = 3'd3,
      ST_OFFER      = 3'd4,
      ST_FRAME_DONE = 3'd5
   } state_t;

   // Counter width that still gives a 1-bit field for a single-entry range.
   function automatic int idx_width(input int n);
      return (n > 1) ? $clog2(n) : 1;
   endfunction

endpackage
`default_nettype wire

// File: rtl/animation_scheduler_if.sv
`default_nettype none
// ============================================================================
// animation_scheduler_if : loader request/data and downstream point stream (rev 1.0)
// ============================================================================
interface animation_scheduler_if
   import animation_pkg::*;
#(
   parameter int N_VIRTUAL_POINTS = DEFAULT_N_VIRTUAL_POINTS
);
   localparam int IDX_W = idx_width(N_VIRTUAL_POINTS);

   logic             next_point_out;
   scalars_t         point_scalars_in;
   color_t           point_color_in;

   logic             point_valid_out;
   logic             point_ready_in;
   scalars_t         point_scalars_out;
   color_t           point_color_out;
   logic [IDX_W-1:0] point_index_out;

   modport master (
      output next_point_out,
      input  point_scalars_in,
      input  point_color_in,
      output point_valid_out,
      input  point_ready_in,
      output point_scalars_out,
      output point_color_out,
      output point_index_out
   );

   modport slave (
      input  next_point_out,
      output point_scalars_in,
      output point_color_in,
      input  point_valid_out,
      output point_ready_in,
      input  point_scalars_out,
      input  point_color_out,
      input  point_index_out
   );

endinterface
`default_nettype wire

// File: rtl/wrap_counter.sv
`default_nettype none
// ============================================================================
// wrap_counter : 0..MAX counter with clear and single-cycle wrap pulse (rev 1.0)
// ============================================================================
module wrap_counter #(
   parameter  int MAX = 1,
   localparam int W   = (MAX > 0) ? $clog2(MAX + 1) : 1
) (
   input  wire logic         clk_in,
   input  wire logic         rst_in,
   input  wire logic         inc_in,
   input  wire logic         clear_in,
   output logic [W-1:0]      count_out,
   output logic              wrap_out
);

   logic [W-1:0] count_q;

   assign wrap_out  = inc_in && (count_q == W'(MAX));
   assign count_out = count_q;

   always_ff @(posedge clk_in) begin
      if (rst_in || clear_in) begin
         count_q <= '0;
      end else if (inc_in) begin
         count_q <= wrap_out ? '0 : count_q + 1'b1;
      end
   end

endmodule
`default_nettype wire

// File: rtl/animation_scheduler.sv
`default_nettype none
// ============================================================================
// animation_scheduler : per-vsync frame renderer fetching points from a loader (rev 1.0)
// ============================================================================
module animation_scheduler
   import animation_pkg::*;
#(
   parameter  int N_VIRTUAL_POINTS = DEFAULT_N_VIRTUAL_POINTS,
   parameter  int N_FRAMES         = DEFAULT_N_FRAMES,
   parameter  int LOAD_LATENCY     = 2,
   localparam int IDX_W            = idx_width(N_VIRTUAL_POINTS),
   localparam int FRM_W            = idx_width(N_FRAMES)
) (
   input  wire logic              clk_in,
   input  wire logic              rst_in,
   input  wire logic              play_in,
   input  wire logic              vsync_in,
   animation_scheduler_if.master  pt,
   output logic [FRM_W-1:0]       frame_index_out,
   output logic                   frame_done_out,
   output logic                   overrun_out,
   output logic                   busy_out
);

   state_t     state_q, state_d;
   logic [3:0] lat_q, lat_d;
   scalars_t   scalars_q;
   color_t     color_q;
   logic       overrun_q;

   logic             capture;
   logic             vsync_accept;
   logic             handshake;
   logic             last_point;
   logic             frame_wrap_unused;
   logic [IDX_W-1:0] point_idx;

   assign handshake = (state_q == ST_OFFER) && pt.point_ready_in;

   wrap_counter #(.MAX(N_VIRTUAL_POINTS - 1)) u_point_cnt (
      .clk_in    (clk_in),
      .rst_in    (rst_in),
      .inc_in    (handshake),
      .clear_in  (vsync_accept),
      .count_out (point_idx),
      .wrap_out  (last_point)
   );

   wrap_counter #(.MAX(N_FRAMES - 1)) u_frame_cnt (
      .clk_in    (clk_in),
      .rst_in    (rst_in),
      .inc_in    (state_q == ST_FRAME_DONE),
      .clear_in  (1'b0),
      .count_out (frame_index_out),
      .wrap_out  (frame_wrap_unused)
   );

   always_ff @(posedge clk_in) begin
      if (rst_in) begin
         state_q   <= ST_IDLE;
         lat_q     <= '0;
         scalars_q <= '0;
         color_q   <= '0;
         overrun_q <= 1'b0;
      end else begin
         state_q   <= state_d;
         lat_q     <= lat_d;
         // A vsync landing mid-frame is flagged and otherwise dropped.
         overrun_q <= vsync_in && busy_out;
         if (capture) begin
            scalars_q <= pt.point_scalars_in;
            color_q   <= pt.point_color_in;
         end
      end
   end

   always_comb begin
      state_d      = state_q;
      lat_d        = lat_q;
      capture      = 1'b0;
      vsync_accept = 1'b0;
      case (state_q)
         ST_IDLE: begin
            if (play_in) state_d = ST_WAIT_VSYNC;
         end
         ST_WAIT_VSYNC: begin
            if (vsync_in) begin
               vsync_accept = 1'b1;
               state_d      = ST_ISSUE;
            end else if (!play_in) begin
               state_d = ST_IDLE;
            end
         end
         ST_ISSUE: begin
            lat_d   = 4'(LOAD_LATENCY - 1);
            state_d = ST_WAIT_DATA;
         end
         ST_WAIT_DATA: begin
            if (lat_q == 4'd0) begin
               capture = 1'b1;
               state_d = ST_OFFER;
            end else begin
               lat_d = lat_q - 4'd1;
            end
         end
         ST_OFFER: begin
            if (handshake) state_d = last_point ? ST_FRAME_DONE : ST_ISSUE;
         end
         ST_FRAME_DONE: begin
            state_d = play_in ? ST_WAIT_VSYNC : ST_IDLE;
         end
         default: state_d = ST_IDLE;
      endcase
   end

   assign pt.next_point_out    = (state_q == ST_ISSUE);
   assign pt.point_valid_out   = (state_q == ST_OFFER);
   assign pt.point_scalars_out = scalars_q;
   assign pt.point_color_out   = color_q;
   assign pt.point_index_out   = point_idx;
   assign frame_done_out       = (state_q == ST_FRAME_DONE);
   assign overrun_out          = overrun_q;
   assign busy_out             = (state_q != ST_IDLE) && (state_q != ST_WAIT_VSYNC);

endmodule
`default_nettype wire

// File: tb/tb_animation_scheduler.sv
`default_nettype none
// ============================================================================
// tb_animation_scheduler : directed scoreboard bench with a latency-exact loader model (rev 1.0)
// ============================================================================
module tb_animation_scheduler;
   import animation_pkg::*;

   localparam int NP    = 48;
   localparam int NF    = 4;
   localparam int LL    = 2;
   localparam int IDX_W = idx_width(NP);
   localparam int FRM_W = idx_width(NF);

   typedef struct packed {
      logic [IDX_W-1:0] idx;
      scalars_t         sc;
      color_t           col;
   } exp_t;

   logic             clk = 1'b0;
   logic             rst = 1'b1;
   logic             play = 1'b0;
   logic             vsync = 1'b0;
   logic [FRM_W-1:0] frame_index;
   logic             frame_done, overrun, busy;

   int   checks = 0, errors = 0;
   int   np_cnt = 0, fd_cnt = 0, ov_cnt = 0;
   int   req_total = 0, exp_idx = 0, frame_base = 0, exp_frame = 0;
   exp_t sbq[$];

   animation_scheduler_if #(.N_VIRTUAL_POINTS(NP)) pif ();

   animation_scheduler #(
      .N_VIRTUAL_POINTS (NP),
      .N_FRAMES         (NF),
      .LOAD_LATENCY     (LL)
   ) dut (
      .clk_in          (clk),
      .rst_in          (rst),
      .play_in         (play),
      .vsync_in        (vsync),
      .pt              (pif),
      .frame_index_out (frame_index),
      .frame_done_out  (frame_done),
      .overrun_out     (overrun),
      .busy_out        (busy)
   );

   always #5 clk = ~clk;

   function automatic scalars_t pat_sc(input int r);
      scalars_t s;
      s[0] = 16'(r * 3 + 1);
      s[1] = 16'(r * 5 + 7);
      s[2] = 16'(r) ^ 16'hA5A5;
      return s;
   endfunction

   function automatic color_t pat_col(input int r);
      return 4'(r * 7 + 3);
   endfunction

   task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
      checks++;
      assert (obs === exp) else begin
         errors++;
         $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
      end
   endtask

   // Loader: data for a request is valid exactly LL cycles after the pulse, garbage otherwise.
   initial begin
      exp_t pipe [LL];
      logic req;
      for (int i = 0; i < LL; i++) pipe[i] = '0;
      pif.point_scalars_in = '1;
      pif.point_color_in   = '1;
      forever begin
         @(negedge clk);
         req = pif.next_point_out && !rst;
         @(posedge clk);
         #1;
         if (rst) begin
            for (int i = 0; i < LL; i++) pipe[i] = '0;
         end else begin
            for (int i = LL - 1; i > 0; i--) pipe[i] = pipe[i-1];
            if (req) begin
               pipe[0].idx = IDX_W'(exp_idx);
               pipe[0].sc  = pat_sc(req_total);
               pipe[0].col = pat_col(req_total);
               sbq.push_back(pipe[0]);
               req_total++;
               exp_idx++;
            end else begin
               pipe[0].idx = '0;
               pipe[0].sc  = {3{16'hDEAD}};
               pipe[0].col = 4'hE;
            end
         end
         pif.point_scalars_in = pipe[LL-1].sc;
         pif.point_color_in   = pipe[LL-1].col;
      end
   end

   // Monitor: pulse counters and scoreboard pop on every accepted point.
   initial begin
      exp_t e;
      forever begin
         @(negedge clk);
         #1;
         if (!rst) begin
            if (pif.next_point_out) np_cnt++;
            if (frame_done)         fd_cnt++;
            if (overrun)            ov_cnt++;
            if (pif.point_valid_out && pif.point_ready_in) begin
               check("sb_nonempty", 64'(sbq.size() > 0), 64'd1);
               if (sbq.size() > 0) begin
                  e = sbq.pop_front();
                  check("point_index", pif.point_index_out, e.idx);
                  check("point_scalars", pif.point_scalars_out, e.sc);
                  check("point_color", pif.point_color_out, e.col);
               end
            end
         end
      end
   end

   initial begin
      #500000;
      $display("FAIL watchdog: simulation did not complete");
      $fatal(1, "watchdog expired");
   end

   task automatic pulse_vsync();
      vsync = 1'b1;
      @(negedge clk);
      vsync = 1'b0;
   endtask

   task automatic start_frame();
      exp_idx    = 0;
      np_cnt     = 0;
      frame_base = req_total;
      pulse_vsync();
   endtask

   task automatic wait_valid_idx(input int k);
      int n = 0;
      while (!(pif.point_valid_out && (pif.point_index_out == IDX_W'(k))) && n < 500) begin
         @(negedge clk);
         n++;
      end
      check($sformatf("reach_idx%0d", k), 64'(n < 500), 64'd1);
   endtask

   task automatic finish_frame();
      int n = 0;
      while (!frame_done && n < 1000) begin
         @(negedge clk);
         n++;
      end
      check("frame_done_seen", 64'(n < 1000), 64'd1);
      @(negedge clk);
      exp_frame = (exp_frame + 1) % NF;
      check("frame_index", frame_index, exp_frame);
      check("np_per_frame", np_cnt, NP);
      check("sb_drained", sbq.size(), 0);
   endtask

   initial begin
      int ov0, np0, fd0;
      pif.point_ready_in = 1'b1;
      repeat (3) @(negedge clk);
      check("rst_valid", pif.point_valid_out, 0);
      check("rst_next_point", pif.next_point_out, 0);
      check("rst_index", pif.point_index_out, 0);
      check("rst_scalars", pif.point_scalars_out, 0);
      check("rst_frame_index", frame_index, 0);
      check("rst_busy", busy, 0);
      check("rst_frame_done", frame_done, 0);
      check("rst_overrun", overrun, 0);

      rst  = 1'b0;
      play = 1'b1;
      repeat (2) @(negedge clk);
      check("wait_vsync_not_busy", busy, 0);

      // Frame 1: first valid exactly LL+1 cycles after the accepting edge.
      start_frame();
      @(negedge clk);
      @(negedge clk);
      check("first_valid_early", pif.point_valid_out, 0);
      @(negedge clk);
      check("first_valid_on_time", pif.point_valid_out, 1);
      check("first_index", pif.point_index_out, 0);
      finish_frame();

      for (int f = 1; f < 5; f++) begin
         start_frame();
         if (f == 1) begin
            wait_valid_idx(5);
            pif.point_ready_in = 1'b0;
            np0 = np_cnt;
            repeat (10) begin
               @(negedge clk);
               check("stall_valid", pif.point_valid_out, 1);
               check("stall_index", pif.point_index_out, 5);
               check("stall_scalars", pif.point_scalars_out, pat_sc(frame_base + 5));
               check("stall_color", pif.point_color_out, pat_col(frame_base + 5));
            end
            check("stall_no_extra_req", np_cnt, np0);
            pif.point_ready_in = 1'b1;
            finish_frame();
         end else if (f == 2) begin
            wait_valid_idx(20);
            ov0 = ov_cnt;
            pulse_vsync();
            finish_frame();
            check("overrun_once", ov_cnt, ov0 + 1);
            repeat (10) @(negedge clk);
            check("no_restart_busy", busy, 0);
            check("no_restart_np", np_cnt, NP);
         end else begin
            finish_frame();
         end
      end
      check("frame_done_total", fd_cnt, 5);
      check("frame_index_after5", frame_index, 1);

      // Play dropped mid-frame: frame completes, then idle ignores vsync.
      start_frame();
      wait_valid_idx(30);
      play = 1'b0;
      finish_frame();
      ov0 = ov_cnt;
      fd0 = fd_cnt;
      pulse_vsync();
      repeat (10) @(negedge clk);
      check("idle_busy", busy, 0);
      check("idle_np_unchanged", np_cnt, NP);
      check("idle_no_overrun", ov_cnt, ov0);
      check("idle_no_frame_done", fd_cnt, fd0);

      // Reset mid-frame, then restart from point 0.
      play = 1'b1;
      repeat (2) @(negedge clk);
      start_frame();
      wait_valid_idx(17);
      rst = 1'b1;
      @(negedge clk);
      rst = 1'b0;
      sbq.delete();
      check("midrst_valid", pif.point_valid_out, 0);
      check("midrst_index", pif.point_index_out, 0);
      check("midrst_scalars", pif.point_scalars_out, 0);
      check("midrst_color", pif.point_color_out, 0);
      check("midrst_frame_index", frame_index, 0);
      check("midrst_busy", busy, 0);
      check("midrst_next_point", pif.next_point_out, 0);
      exp_frame = 0;
      repeat (2) @(negedge clk);
      start_frame();
      wait_valid_idx(0);
      finish_frame();

      repeat (5) @(negedge clk);
      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

endmodule
`default_nettype wire
